// File: rtl/step_pulse_gen.sv
// CPU clock-enable generator: free-running divider in RUN mode, debounced
// single-step button in STEP mode, plus a running count of issued pulses.
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIVIDE      = 20_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_btn,
    output logic        cpu_en,
    output logic        btn_clean,
    output logic [15:0] step_count,
    output logic        mode_run
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RUN_W = $clog2(RUN_DIVIDE + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIVIDE - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    logic [1:0]       mode_sync_q, mode_sync_d;
    logic [1:0]       btn_sync_q,  btn_sync_d;
    logic [DB_W-1:0]  db_cnt_q,    db_cnt_d;
    logic             btn_clean_q, btn_clean_d;
    logic             btn_d_q,     btn_d_d;
    state_e           state_q,     state_d;
    logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
    logic             cpu_en_q,    cpu_en_d;
    logic [15:0]      step_count_q, step_count_d;

    logic mode_synced_s;
    logic btn_synced_s;
    logic btn_rise_s;
    logic run_pulse_s;
    logic step_pulse_s;

    assign mode_synced_s = mode_sync_q[1];
    assign btn_synced_s  = btn_sync_q[1];
    assign btn_rise_s    = btn_clean_q & ~btn_d_q;

    // Two-flop synchronizers for both asynchronous inputs.
    always_comb begin
        mode_sync_d = {mode_sync_q[0], run_mode};
        btn_sync_d  = {btn_sync_q[0], step_btn};
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        btn_clean_d = btn_clean_q;
        if (btn_synced_s == btn_clean_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_clean_d = btn_synced_s;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
        btn_d_d = btn_clean_q;
    end

    // Mode FSM and pulse sources; run_cnt only advances while in RUN.
    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        run_pulse_s  = 1'b0;
        step_pulse_s = 1'b0;
        case (state_q)
            ST_STEP: begin
                run_cnt_d = '0;
                if (mode_synced_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STEP;
                end
                // Suppressing right after a pulse keeps cpu_en from ever being high twice in a row.
                if (btn_rise_s && !cpu_en_q) begin
                    step_pulse_s = 1'b1;
                end else begin
                    step_pulse_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    run_cnt_d   = '0;
                    run_pulse_s = 1'b1;
                end else begin
                    run_cnt_d   = run_cnt_q + RUN_ONE;
                    run_pulse_s = 1'b0;
                end
                if (!mode_synced_s) begin
                    state_d   = ST_STEP;
                    run_cnt_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_STEP;
                run_cnt_d = '0;
            end
        endcase
    end

    // Output pulse register and pulse counter (wraps naturally at 16 bits).
    always_comb begin
        cpu_en_d     = run_pulse_s | step_pulse_s;
        step_count_d = step_count_q + {15'd0, cpu_en_q};
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_sync_q  <= 2'b00;
            btn_sync_q   <= 2'b00;
            db_cnt_q     <= '0;
            btn_clean_q  <= 1'b0;
            btn_d_q      <= 1'b0;
            state_q      <= ST_STEP;
            run_cnt_q    <= '0;
            cpu_en_q     <= 1'b0;
            step_count_q <= 16'h0000;
        end else begin
            mode_sync_q  <= mode_sync_d;
            btn_sync_q   <= btn_sync_d;
            db_cnt_q     <= db_cnt_d;
            btn_clean_q  <= btn_clean_d;
            btn_d_q      <= btn_d_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign btn_clean  = btn_clean_q;
    assign step_count = step_count_q;
    assign mode_run   = (state_q == ST_RUN);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen (DEBOUNCE_CYCLES=4, RUN_DIVIDE=5):
// stimulus queues expected pulse cycles, a negedge monitor checks each pulse.
module tb_step_pulse_gen;

    logic        clk;
    logic        reset;
    logic        run_mode;
    logic        step_btn;
    logic        cpu_en;
    logic        btn_clean;
    logic [15:0] step_count;
    logic        mode_run;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIVIDE     (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_mode  (run_mode),
        .step_btn  (step_btn),
        .cpu_en    (cpu_en),
        .btn_clean (btn_clean),
        .step_count(step_count),
        .mode_run  (mode_run)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_cnt = 16'h0000;
    logic        prev_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected pulse at edge c, carrying the count visible while cpu_en is high.
    task automatic push_exp(input int unsigned c);
        exp_t e;
        e.cyc = c;
        e.cnt = model_cnt;
        sb.push_back(e);
        model_cnt = model_cnt + 16'd1;
    endtask

    // run_mode raised after edge c0 and dropped after edge c0+len: RUN starts at c0+3
    // (two sync flops + state flop) and the last pulse can land on edge c0+len+3.
    task automatic push_run(input int unsigned c0, input int unsigned len);
        for (int unsigned k = c0 + 8; k <= c0 + len + 3; k += 5) push_exp(k);
    endtask

    always @(negedge clk) begin
        if (reset && cpu_en) begin
            checks++;
            if (prev_en) begin
                failures++;
                $display("FAIL consecutive_pulse actual=1 required=0 at cyc=%0d", cyc);
            end
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse at cyc=%0d count=%0h", cyc, step_count);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_count", {16'd0, step_count}, {16'd0, mon_e.cnt});
            end
        end
        prev_en <= cpu_en;
    end

    initial begin
        int unsigned c0;
        logic        any_clean;
        reset    = 1'b0;
        run_mode = 1'b0;
        step_btn = 1'b0;
        idle(3);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_btn_clean", {31'd0, btn_clean}, 32'd0);
        check("rst_step_count", {16'd0, step_count}, 32'd0);
        check("rst_mode_run", {31'd0, mode_run}, 32'd0);
        reset = 1'b1;
        idle(1);
        check("post_rst_cpu_en", {31'd0, cpu_en}, 32'd0);

        // Clean press: pulse 7 edges after the input edge.
        c0 = cyc;
        step_btn = 1'b1;
        push_exp(c0 + 7);
        idle(20);
        check("press_btn_clean", {31'd0, btn_clean}, 32'd1);
        step_btn = 1'b0;
        idle(10);
        check("release_btn_clean", {31'd0, btn_clean}, 32'd0);
        check("press_count", {16'd0, step_count}, {16'd0, model_cnt});

        // Bounce: 2-cycle pulses never survive the 4-cycle debounce.
        any_clean = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_btn = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                any_clean = any_clean | btn_clean;
            end
        end
        step_btn = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_clean = any_clean | btn_clean;
        end
        check("bounce_btn_clean", {31'd0, any_clean}, 32'd0);
        check("bounce_count", {16'd0, step_count}, {16'd0, model_cnt});

        // Free run for 40 cycles: 8 pulses spaced by 5.
        c0 = cyc;
        run_mode = 1'b1;
        push_run(c0, 40);
        idle(2);
        check("run_mode_run_early", {31'd0, mode_run}, 32'd0);
        idle(1);
        check("run_mode_run_entry", {31'd0, mode_run}, 32'd1);
        idle(37);
        run_mode = 1'b0;
        idle(10);
        check("run_mode_run_exit", {31'd0, mode_run}, 32'd0);
        check("run_count", {16'd0, step_count}, 32'd9);

        // Button pressed during RUN and held across RUN->STEP, then a fresh press.
        c0 = cyc;
        run_mode = 1'b1;
        push_run(c0, 20);
        idle(4);
        step_btn = 1'b1;
        idle(16);
        run_mode = 1'b0;
        idle(20);
        step_btn = 1'b0;
        idle(20);
        c0 = cyc;
        step_btn = 1'b1;
        push_exp(c0 + 7);
        idle(12);
        step_btn = 1'b0;
        idle(10);
        check("switch_count", {16'd0, step_count}, 32'd14);

        // Wrap: preload near the top, then three run pulses roll over to zero.
        force dut.step_count_q = 16'hFFFD;
        @(posedge clk);
        #1 release dut.step_count_q;
        model_cnt = 16'hFFFD;
        idle(1);
        check("preload_count", {16'd0, step_count}, 32'h0000FFFD);
        c0 = cyc;
        run_mode = 1'b1;
        push_run(c0, 16);
        idle(16);
        run_mode = 1'b0;
        idle(10);
        check("wrap_count", {16'd0, step_count}, 32'h00000000);

        // Async reset mid-run, between clock edges.
        c0 = cyc;
        run_mode = 1'b1;
        push_exp(c0 + 8);
        push_exp(c0 + 13);
        idle(15);
        @(posedge clk);
        #1;
        check("pre_rst_mode_run", {31'd0, mode_run}, 32'd1);
        check("pre_rst_count", {16'd0, step_count}, 32'd2);
        #1 reset = 1'b0;
        #1;
        check("async_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("async_mode_run", {31'd0, mode_run}, 32'd0);
        check("async_count", {16'd0, step_count}, 32'd0);
        check("async_btn_clean", {31'd0, btn_clean}, 32'd0);
        sb.delete();
        model_cnt = 16'h0000;
        idle(2);
        reset = 1'b1;
        c0 = cyc;
        push_run(c0, 20);
        idle(3);
        check("rerun_mode_run", {31'd0, mode_run}, 32'd1);
        idle(17);
        run_mode = 1'b0;
        idle(10);
        check("rerun_count", {16'd0, step_count}, 32'd4);

        check("missing_pulses", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
